// File: rtl/pipe_pkg.sv
// Shared constants for the pipe gap generator and the pipe mover: Y limits,
// LFSR seed/taps and the gap generator state encoding.
package pipe_pkg;

  localparam int unsigned MIN_Y     = 100;
  localparam int unsigned MAX_Y     = 400;
  localparam int unsigned DEFAULT_Y = 260;
  localparam int unsigned GAP_RANGE = MAX_Y - MIN_Y + 1;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    IDLE   = 1'b0,
    REDUCE = 1'b1
  } gap_state_e;

  // A zero seed would lock the LFSR up, so it is swapped for the default seed.
  function automatic logic [15:0] fix_seed(input logic [15:0] s);
    return (s == 16'd0) ? LFSR_SEED : s;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR with a synchronous seed load.
// It never holds zero because a zero seed is replaced by LFSR_SEED.
module lfsr16
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    if (load) begin
      lfsr_d = fix_seed(seed);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/pipe_gap_gen.sv
// Gap height generator: samples the LFSR on request and reduces the sample
// modulo the gap range one bit per cycle, then offsets it into [MIN_Y, MAX_Y].
module pipe_gap_gen
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic [9:0]  gap_y,
  output logic        valid,
  output logic        busy
);

  localparam logic [10:0] RANGE_W   = 11'(GAP_RANGE);
  localparam logic [9:0]  MIN_Y_W   = 10'(MIN_Y);
  localparam logic [9:0]  DEFAULT_W = 10'(DEFAULT_Y);

  gap_state_e  state_q, state_d;
  logic [15:0] sample_q, sample_d;
  logic [9:0]  rem_q, rem_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  gap_y_q, gap_y_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  logic [15:0] lfsr_val;
  logic [15:0] cap;
  logic [10:0] trial;
  logic [9:0]  rem_next;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (seed_load),
    .seed  (seed),
    .q     (lfsr_val)
  );

  // Capture the pre-advance value so a simultaneous seed load is deterministic.
  assign cap = seed_load ? fix_seed(seed) : lfsr_val;

  always_comb begin
    trial    = {rem_q, sample_q[4'd15 - cnt_q]};
    rem_next = (trial >= RANGE_W) ? 10'(trial - RANGE_W) : trial[9:0];
  end

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    gap_y_d  = gap_y_q;
    valid_d  = valid_q;
    busy_d   = busy_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          sample_d = cap;
          rem_d    = 10'd0;
          cnt_d    = 4'd0;
          busy_d   = 1'b1;
          valid_d  = 1'b0;
          state_d  = REDUCE;
        end
      end
      REDUCE: begin
        rem_d = rem_next;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          gap_y_d = MIN_Y_W + rem_next;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sample_q <= 16'd0;
      rem_q    <= 10'd0;
      cnt_q    <= 4'd0;
      gap_y_q  <= DEFAULT_W;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      gap_y_q  <= gap_y_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign gap_y = gap_y_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_pipe_gap_gen.sv
// Directed self-checking bench for pipe_gap_gen; expected values are worked
// out by hand from the LFSR tap rule and sample mod 301 plus 100.
module tb_pipe_gap_gen;

  logic        clk;
  logic        reset;
  logic        req;
  logic        seed_load;
  logic [15:0] seed;
  logic [9:0]  gap_y;
  logic        valid;
  logic        busy;

  int checks;
  int fails;
  bit range_en;

  pipe_gap_gen dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .seed_load (seed_load),
    .seed      (seed),
    .gap_y     (gap_y),
    .valid     (valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gap_y must stay inside the legal window on every cycle once reset has run.
  always @(negedge clk) begin
    if (range_en) begin
      checks++;
      if (gap_y < 10'd100 || gap_y > 10'd400) begin
        fails++;
        $display("[TB] FAIL gap_range: gap_y=%0d required within [100,400]", gap_y);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps the clock until busy drops, capped so a stuck DUT cannot hang the run.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = 1'b0;
    seed_load = 1'b0;
    seed = 16'h0000;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] exp_lfsr [3];
    exp_lfsr[0] = 16'hACE1;
    exp_lfsr[1] = 16'hE270;
    exp_lfsr[2] = 16'h7138;
    reset = 1'b1;
    tick();
    do_reset();
    range_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dut.u_lfsr.q !== exp_lfsr[i]) begin
        fails++;
        $display("[TB] FAIL reset_lfsr[%0d]: got %h expected %h", i, dut.u_lfsr.q, exp_lfsr[i]);
      end
      tick();
    end
    repeat (2) tick();
    checks++;
    if (gap_y !== 10'd260 || valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got gap_y=%0d valid=%b busy=%b expected 260/0/0",
               gap_y, valid, busy);
    end
  endtask

  task automatic test_first_req();
    int cyc;
    do_reset();
    req = 1'b1;
    tick();
    req = 1'b0;
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0 || gap_y !== 10'd260) begin
      fails++;
      $display("[TB] FAIL first_req_start: got busy=%b valid=%b gap_y=%0d expected 1/0/260",
               busy, valid, gap_y);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 16) begin
      fails++;
      $display("[TB] FAIL first_req_latency: got %0d cycles expected 16", cyc);
    end
    checks++;
    if (gap_y !== 10'd110 || valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL first_req_value: got gap_y=%0d valid=%b expected 110/1", gap_y, valid);
    end
    repeat (3) tick();
    checks++;
    if (valid !== 1'b1 || gap_y !== 10'd110) begin
      fails++;
      $display("[TB] FAIL valid_hold: got gap_y=%0d valid=%b expected 110/1", gap_y, valid);
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] seeds [4];
    logic [9:0]  exp_y [4];
    int cyc;
    seeds[0] = 16'h012D; exp_y[0] = 10'd100;
    seeds[1] = 16'h012C; exp_y[1] = 10'd400;
    seeds[2] = 16'h0001; exp_y[2] = 10'd101;
    seeds[3] = 16'h0000; exp_y[3] = 10'd110;
    for (int i = 0; i < 4; i++) begin
      seed_load = 1'b1;
      seed = seeds[i];
      req = 1'b1;
      tick();
      seed_load = 1'b0;
      req = 1'b0;
      if (i == 3) begin
        checks++;
        if (dut.u_lfsr.q !== 16'hACE1) begin
          fails++;
          $display("[TB] FAIL zero_seed_lfsr: got %h expected ace1", dut.u_lfsr.q);
        end
      end
      wait_done(cyc);
      checks++;
      if (cyc !== 16 || gap_y !== exp_y[i] || valid !== 1'b1) begin
        fails++;
        $display("[TB] FAIL boundary[%0d]: got gap_y=%0d valid=%b cycles=%0d expected %0d/1/16",
                 i, gap_y, valid, cyc, exp_y[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    seed_load = 1'b1;
    seed = 16'h012D;
    req = 1'b1;
    tick();
    for (int k = 1; k <= 17; k++) begin
      req = (k == 3 || k == 10 || k >= 16);
      seed_load = (k == 10 || k >= 16);
      seed = (k == 10) ? 16'h0001 : 16'h012C;
      tick();
      if (k < 16) begin
        checks++;
        if (busy !== 1'b1 || valid !== 1'b0 || gap_y !== 10'd110) begin
          fails++;
          $display("[TB] FAIL overlap_busy[%0d]: got busy=%b valid=%b gap_y=%0d expected 1/0/110",
                   k, busy, valid, gap_y);
        end
      end else if (k == 16) begin
        checks++;
        if (busy !== 1'b0 || valid !== 1'b1 || gap_y !== 10'd100) begin
          fails++;
          $display("[TB] FAIL overlap_done: got busy=%b valid=%b gap_y=%0d expected 0/1/100",
                   busy, valid, gap_y);
        end
      end else begin
        checks++;
        if (busy !== 1'b1 || valid !== 1'b0 || gap_y !== 10'd100) begin
          fails++;
          $display("[TB] FAIL held_req_retrigger: got busy=%b valid=%b gap_y=%0d expected 1/0/100",
                   busy, valid, gap_y);
        end
      end
    end
    req = 1'b0;
    seed_load = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc !== 16 || gap_y !== 10'd400 || valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL held_req_value: got gap_y=%0d valid=%b cycles=%0d expected 400/1/16",
               gap_y, valid, cyc);
    end
  endtask

  task automatic test_abort();
    int cyc;
    seed_load = 1'b1;
    seed = 16'h012C;
    req = 1'b1;
    tick();
    seed_load = 1'b0;
    req = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (gap_y !== 10'd260 || valid !== 1'b0 || busy !== 1'b0 || dut.u_lfsr.q !== 16'hACE1) begin
      fails++;
      $display("[TB] FAIL abort_state: got gap_y=%0d valid=%b busy=%b lfsr=%h expected 260/0/0/ace1",
               gap_y, valid, busy, dut.u_lfsr.q);
    end
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc !== 16 || gap_y !== 10'd110 || valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL abort_rerun: got gap_y=%0d valid=%b cycles=%0d expected 110/1/16",
               gap_y, valid, cyc);
    end
  endtask

  initial begin
    checks = 0;
    fails = 0;
    range_en = 1'b0;
    reset = 1'b1;
    req = 1'b0;
    seed_load = 1'b0;
    seed = 16'h0000;
    test_reset();
    test_first_req();
    test_boundaries();
    test_back_to_back();
    test_abort();
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
